// File: rtl/zero_stuff_interpolator_pkg.sv
// Shared definitions for the polyphase interpolator/decimator family:
// default ratio bound, ratio port width and ratio sanitising.
package zero_stuff_interpolator_pkg;

  // Default largest interpolation/decimation factor. The matching decimator
  // and the FIR instantiation use the same value.
  localparam int DEFAULT_MAX_RATIO = 16;

  // Output control state: the output holding register is either empty or full.
  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  // Width needed to carry ratios 0..max_ratio on a port.
  function automatic int ratio_width(input int max_ratio);
    return $clog2(max_ratio + 1);
  endfunction

  // Map a requested ratio onto the supported range 1..max_ratio.
  function automatic int sanitize_ratio(input int requested, input int max_ratio);
    if (requested <= 0) begin
      return 1;
    end
    if (requested > max_ratio) begin
      return max_ratio;
    end
    return requested;
  endfunction

endpackage

// File: rtl/zero_stuff_interpolator.sv
// AXI-Stream zero-stuffing upsampler feeding the polyphase FIR input.
// Each accepted sample is emitted followed by ratio_active-1 zero beats;
// the frame tlast is moved onto the final stuffed beat.
//
// state | meaning
// IDLE  | output register empty (m_tvalid=0)
// EMIT  | output register holds a beat (m_tvalid=1)
module zero_stuff_interpolator
  import zero_stuff_interpolator_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int MAX_RATIO   = DEFAULT_MAX_RATIO,
  parameter int RATIO_WIDTH = ratio_width(MAX_RATIO)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [RATIO_WIDTH-1:0] ratio,
  input  logic [DATA_WIDTH-1:0]  s_tdata,
  input  logic                   s_tvalid,
  output logic                   s_tready,
  input  logic                   s_tlast,
  output logic [DATA_WIDTH-1:0]  m_tdata,
  output logic                   m_tvalid,
  input  logic                   m_tready,
  output logic                   m_tlast,
  output logic                   busy
);

  state_t                 state;
  state_t                 state_next;
  logic [RATIO_WIDTH-1:0] phase;
  logic [RATIO_WIDTH-1:0] ratio_active;
  logic [RATIO_WIDTH-1:0] ratio_clamped;
  logic [RATIO_WIDTH-1:0] eff_ratio;
  logic [RATIO_WIDTH-1:0] last_phase;
  logic [RATIO_WIDTH-1:0] phase_next;
  logic                   frame_start;
  logic                   last_pending;
  logic                   last_beat;
  logic                   accept;
  logic                   out_xfer;
  logic                   new_frame;

  assign m_tvalid = (state == EMIT);

  // Clamp the requested ratio into 1..MAX_RATIO.
  always_comb begin
    ratio_clamped = RATIO_WIDTH'(sanitize_ratio(int'(ratio), MAX_RATIO));
  end

  // Handshake decode. A frame boundary is either an idle frame_start or the
  // tlast beat leaving in this very cycle, so a back-to-back frame relatches.
  always_comb begin
    last_phase = ratio_active - RATIO_WIDTH'(1);
    phase_next = phase + RATIO_WIDTH'(1);
    last_beat  = m_tvalid && (phase == last_phase);
    s_tready   = !m_tvalid || (m_tready && last_beat);
    accept     = s_tvalid && s_tready;
    out_xfer   = m_tvalid && m_tready;
    new_frame  = frame_start || (out_xfer && m_tlast);
    eff_ratio  = new_frame ? ratio_clamped : ratio_active;
  end

  // Next-state logic: fill on accept, drain after the last stuffed beat.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = EMIT;
      EMIT: begin
        if (accept) begin
          state_next = EMIT;
        end else if (out_xfer && last_beat) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Output holding register, phase counter and frame bookkeeping.
  always_ff @(posedge clock) begin
    if (reset) begin
      m_tdata      <= '0;
      m_tlast      <= 1'b0;
      busy         <= 1'b0;
      phase        <= '0;
      frame_start  <= 1'b1;
      last_pending <= 1'b0;
      ratio_active <= RATIO_WIDTH'(1);
    end else begin
      if (out_xfer && m_tlast) begin
        frame_start  <= 1'b1;
        busy         <= 1'b0;
        last_pending <= 1'b0;
      end
      if (accept) begin
        m_tdata      <= s_tdata;
        m_tlast      <= s_tlast && (eff_ratio == RATIO_WIDTH'(1));
        phase        <= '0;
        last_pending <= s_tlast;
        frame_start  <= 1'b0;
        busy         <= 1'b1;
        if (new_frame) begin
          ratio_active <= ratio_clamped;
        end
      end else if (out_xfer && !last_beat) begin
        phase   <= phase_next;
        m_tdata <= '0;
        m_tlast <= last_pending && (phase_next == last_phase);
      end else if (out_xfer) begin
        m_tlast <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_zero_stuff_interpolator.sv
// Directed bench for zero_stuff_interpolator: beats are captured by a
// negedge monitor and compared against hand-computed frames.
module tb_zero_stuff_interpolator;

  logic        clock = 1'b0;
  logic        reset;
  logic [4:0]  ratio;
  logic [15:0] s_tdata;
  logic        s_tvalid;
  logic        s_tready;
  logic        s_tlast;
  logic [15:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tlast;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [15:0] cap_data[$];
  logic        cap_last[$];
  int          cap_cyc[$];
  int          acc_cyc[$];
  logic [15:0] in_data[$];
  logic        in_last[$];

  zero_stuff_interpolator #(.DATA_WIDTH(16), .MAX_RATIO(16)) dut (
    .clock(clock), .reset(reset), .ratio(ratio),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
    .busy(busy)
  );

  always #5 clock = ~clock;

  // Cycle counter.
  always @(posedge clock) cyc <= cyc + 1;

  // Record every output transfer and input accept that the next edge commits.
  always @(negedge clock) begin
    if (!reset) begin
      if (m_tvalid && m_tready) begin
        cap_data.push_back(m_tdata);
        cap_last.push_back(m_tlast);
        cap_cyc.push_back(cyc);
      end
      if (s_tvalid && s_tready) acc_cyc.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_capture();
    cap_data.delete();
    cap_last.delete();
    cap_cyc.delete();
    acc_cyc.delete();
  endtask

  // Present queued samples one at a time, holding each until accepted.
  task automatic drive_queue();
    int  n;
    bit  done;
    while (in_data.size() > 0) begin
      s_tdata  = in_data[0];
      s_tlast  = in_last[0];
      s_tvalid = 1'b1;
      n = 0;
      done = 0;
      while (!done) begin
        @(negedge clock);
        if (s_tready) done = 1;
        tick();
        n++;
        if (!done && n > 100) begin
          checks++;
          errors++;
          $display("FAIL accept_timeout data=%h not accepted in 100 cycles", s_tdata);
          in_data.delete();
          in_last.delete();
          done = 1;
        end
      end
      if (in_data.size() > 0) begin
        void'(in_data.pop_front());
        void'(in_last.pop_front());
      end
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tdata  = '0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || m_tvalid) && n < 300) begin
      tick();
      n++;
    end
    checks++;
    if (busy !== 1'b0 || m_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL idle_timeout busy=%b m_tvalid=%b expected 0 0", busy, m_tvalid);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; ratio = 5'd1; s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b1;
    repeat (3) tick();
    checks++;
    if (m_tvalid !== 1'b0 || m_tlast !== 1'b0 || m_tdata !== 16'h0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got valid=%b last=%b data=%h busy=%b expected 0 0 0000 0",
               m_tvalid, m_tlast, m_tdata, busy);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (s_tready !== 1'b1) begin
      errors++;
      $display("FAIL reset_s_tready got %b expected 1", s_tready);
    end
  endtask

  task automatic test_basic();
    logic [15:0] exp_d[$];
    logic        exp_l[$];
    clear_capture();
    ratio = 5'd4; m_tready = 1'b1;
    in_data = '{16'h0100, 16'h0200, 16'h0300};
    in_last = '{1'b0, 1'b0, 1'b1};
    exp_d = '{16'h0100, 16'h0, 16'h0, 16'h0, 16'h0200, 16'h0, 16'h0, 16'h0,
              16'h0300, 16'h0, 16'h0, 16'h0};
    exp_l = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    drive_queue();
    wait_idle();
    checks++;
    if (cap_data.size() != exp_d.size()) begin
      errors++;
      $display("FAIL basic_count got %0d beats expected %0d", cap_data.size(), exp_d.size());
    end
    for (int i = 0; i < exp_d.size() && i < cap_data.size(); i++) begin
      checks++;
      if (cap_data[i] !== exp_d[i] || cap_last[i] !== exp_l[i]) begin
        errors++;
        $display("FAIL basic_beat%0d got %h/%b expected %h/%b", i, cap_data[i], cap_last[i], exp_d[i], exp_l[i]);
      end
    end
    for (int i = 1; i < acc_cyc.size(); i++) begin
      checks++;
      if (acc_cyc[i] - acc_cyc[i-1] != 4) begin
        errors++;
        $display("FAIL basic_accept_gap%0d got %0d expected 4", i, acc_cyc[i] - acc_cyc[i-1]);
      end
    end
    if (cap_cyc.size() == 12) begin
      checks++;
      if (cyc != cap_cyc[11] + 1) begin
        errors++;
        $display("FAIL basic_busy_fall got cycle %0d expected %0d", cyc, cap_cyc[11] + 1);
      end
    end
  endtask

  task automatic test_pass_through();
    clear_capture();
    ratio = 5'd1; m_tready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_data.push_back(16'(i));
      in_last.push_back(i == 8);
    end
    drive_queue();
    wait_idle();
    checks++;
    if (cap_data.size() != 8 || acc_cyc.size() != 8) begin
      errors++;
      $display("FAIL pass_count got %0d beats %0d accepts expected 8 8", cap_data.size(), acc_cyc.size());
    end
    for (int i = 0; i < 8 && i < cap_data.size() && i < acc_cyc.size(); i++) begin
      checks++;
      if (cap_data[i] !== 16'(i + 1) || cap_last[i] !== (i == 7) ||
          cap_cyc[i] != acc_cyc[i] + 1 || acc_cyc[i] != acc_cyc[0] + i) begin
        errors++;
        $display("FAIL pass_beat%0d got %h/%b at cyc %0d expected %h/%b at cyc %0d",
                 i, cap_data[i], cap_last[i], cap_cyc[i], 16'(i + 1), (i == 7), acc_cyc[0] + i + 1);
      end
    end
  endtask

  task automatic test_backpressure();
    logic        pattern[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [15:0] exp_d[$];
    logic        exp_l[$];
    logic [15:0] prev_data;
    logic        prev_last;
    bit          prev_stall;
    clear_capture();
    ratio = 5'd3;
    in_data = '{16'h0011, 16'h0022};
    in_last = '{1'b0, 1'b1};
    exp_d = '{16'h0011, 16'h0, 16'h0, 16'h0022, 16'h0, 16'h0};
    exp_l = '{0, 0, 0, 0, 0, 1};
    prev_stall = 0; prev_data = '0; prev_last = 1'b0;
    fork
      drive_queue();
      begin
        for (int i = 0; i < 7; i++) begin
          m_tready = pattern[i];
          @(negedge clock);
          if (prev_stall) begin
            checks++;
            if (m_tdata !== prev_data || m_tlast !== prev_last) begin
              errors++;
              $display("FAIL bp_hold%0d got %h/%b expected %h/%b", i, m_tdata, m_tlast, prev_data, prev_last);
            end
          end
          if (m_tvalid && !m_tready) begin
            checks++;
            if (s_tready !== 1'b0) begin
              errors++;
              $display("FAIL bp_s_tready%0d got %b expected 0", i, s_tready);
            end
          end
          prev_stall = m_tvalid && !m_tready;
          prev_data  = m_tdata;
          prev_last  = m_tlast;
          tick();
        end
        m_tready = 1'b1;
      end
    join
    wait_idle();
    checks++;
    if (cap_data.size() != exp_d.size()) begin
      errors++;
      $display("FAIL bp_count got %0d beats expected %0d", cap_data.size(), exp_d.size());
    end
    for (int i = 0; i < exp_d.size() && i < cap_data.size(); i++) begin
      checks++;
      if (cap_data[i] !== exp_d[i] || cap_last[i] !== exp_l[i]) begin
        errors++;
        $display("FAIL bp_beat%0d got %h/%b expected %h/%b", i, cap_data[i], cap_last[i], exp_d[i], exp_l[i]);
      end
    end
  endtask

  task automatic test_ratio_latch();
    logic [15:0] exp_d[$];
    logic        exp_l[$];
    clear_capture();
    ratio = 5'd2; m_tready = 1'b1;
    in_data = '{16'h0001};
    in_last = '{1'b0};
    drive_queue();
    ratio = 5'd5;
    in_data = '{16'h0002, 16'h0003};
    in_last = '{1'b1, 1'b1};
    drive_queue();
    wait_idle();
    exp_d = '{16'h0001, 16'h0, 16'h0002, 16'h0, 16'h0003, 16'h0, 16'h0, 16'h0, 16'h0};
    exp_l = '{0, 0, 0, 1, 0, 0, 0, 0, 1};
    checks++;
    if (cap_data.size() != exp_d.size()) begin
      errors++;
      $display("FAIL latch_count got %0d beats expected %0d", cap_data.size(), exp_d.size());
    end
    for (int i = 0; i < exp_d.size() && i < cap_data.size(); i++) begin
      checks++;
      if (cap_data[i] !== exp_d[i] || cap_last[i] !== exp_l[i]) begin
        errors++;
        $display("FAIL latch_beat%0d got %h/%b expected %h/%b", i, cap_data[i], cap_last[i], exp_d[i], exp_l[i]);
      end
    end
    if (cap_cyc.size() >= 5) begin
      checks++;
      if (cap_cyc[4] != cap_cyc[3] + 1) begin
        errors++;
        $display("FAIL latch_bubble got gap %0d expected 1", cap_cyc[4] - cap_cyc[3]);
      end
    end
  endtask

  task automatic test_clamp();
    logic [15:0] exp_d[$];
    logic        exp_l[$];
    clear_capture();
    ratio = 5'd0; m_tready = 1'b1;
    in_data = '{16'h0005, 16'h0006, 16'h0007};
    in_last = '{1'b0, 1'b0, 1'b1};
    drive_queue();
    wait_idle();
    exp_d = '{16'h0005, 16'h0006, 16'h0007};
    exp_l = '{0, 0, 1};
    checks++;
    if (cap_data.size() != exp_d.size()) begin
      errors++;
      $display("FAIL clamp0_count got %0d beats expected %0d", cap_data.size(), exp_d.size());
    end
    for (int i = 0; i < exp_d.size() && i < cap_data.size(); i++) begin
      checks++;
      if (cap_data[i] !== exp_d[i] || cap_last[i] !== exp_l[i]) begin
        errors++;
        $display("FAIL clamp0_beat%0d got %h/%b expected %h/%b", i, cap_data[i], cap_last[i], exp_d[i], exp_l[i]);
      end
    end
    clear_capture();
    ratio = 5'd20;
    in_data = '{16'h0009};
    in_last = '{1'b1};
    drive_queue();
    wait_idle();
    checks++;
    if (cap_data.size() != 16) begin
      errors++;
      $display("FAIL clamp20_count got %0d beats expected 16", cap_data.size());
    end
    for (int i = 0; i < 16 && i < cap_data.size(); i++) begin
      checks++;
      if (cap_data[i] !== ((i == 0) ? 16'h0009 : 16'h0) || cap_last[i] !== (i == 15)) begin
        errors++;
        $display("FAIL clamp20_beat%0d got %h/%b expected %h/%b",
                 i, cap_data[i], cap_last[i], (i == 0) ? 16'h0009 : 16'h0, (i == 15));
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int n = 0;
    logic [15:0] exp_d[$];
    logic        exp_l[$];
    clear_capture();
    ratio = 5'd4; m_tready = 1'b1;
    in_data = '{16'h000A};
    in_last = '{1'b0};
    drive_queue();
    in_data = '{16'h000B};
    in_last = '{1'b1};
    drive_queue();
    while (cap_data.size() < 6 && n < 50) begin
      tick();
      n++;
    end
    reset = 1'b1;
    tick();
    checks++;
    if (m_tvalid !== 1'b0 || busy !== 1'b0 || m_tlast !== 1'b0 || m_tdata !== 16'h0) begin
      errors++;
      $display("FAIL midreset_outputs got valid=%b busy=%b last=%b data=%h expected 0 0 0 0000",
               m_tvalid, busy, m_tlast, m_tdata);
    end
    for (int i = 0; i < cap_last.size(); i++) begin
      checks++;
      if (cap_last[i] !== 1'b0) begin
        errors++;
        $display("FAIL midreset_tlast%0d got %b expected 0", i, cap_last[i]);
      end
    end
    reset = 1'b0;
    tick();
    clear_capture();
    ratio = 5'd2;
    in_data = '{16'h0021, 16'h0022};
    in_last = '{1'b0, 1'b1};
    drive_queue();
    wait_idle();
    exp_d = '{16'h0021, 16'h0, 16'h0022, 16'h0};
    exp_l = '{0, 0, 0, 1};
    checks++;
    if (cap_data.size() != exp_d.size()) begin
      errors++;
      $display("FAIL restart_count got %0d beats expected %0d", cap_data.size(), exp_d.size());
    end
    for (int i = 0; i < exp_d.size() && i < cap_data.size(); i++) begin
      checks++;
      if (cap_data[i] !== exp_d[i] || cap_last[i] !== exp_l[i]) begin
        errors++;
        $display("FAIL restart_beat%0d got %h/%b expected %h/%b", i, cap_data[i], cap_last[i], exp_d[i], exp_l[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_pass_through();
    test_backpressure();
    test_ratio_latch();
    test_clamp();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
